pspin_pkt_alloc: RTL and testbench

//  Packet-buffer slot allocator directly upstream of the PsPIN ingress DMA stage.

---
 rtl/pspin_pkt_alloc.sv | 143 ++++++++++++++
 tb/tb_pspin_pkt_alloc.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pspin_pkt_alloc.sv
`default_nettype none
// ============================================================================
//  Module   : pspin_pkt_alloc
//  Purpose  : Fixed-size packet-buffer slot allocator feeding the PsPIN
//             ingress DMA. Hands out the lowest free slot per request,
//             issues a registered write descriptor and reclaims slots from
//             PsPIN feedback in any order.
//  Revision : 1.0 - initial release
// ============================================================================
module pspin_pkt_alloc #(
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter int                        LEN_WIDTH      = 20,
  parameter int                        TAG_WIDTH      = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] BUF_START      = 32'h1c40_0000,
  parameter int                        SLOT_SIZE      = 2048,
  parameter int                        NUM_SLOTS      = 32
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [LEN_WIDTH-1:0]           s_pkt_len,
  input  logic [TAG_WIDTH-1:0]           s_pkt_tag,
  input  logic                           s_pkt_valid,
  output logic                           s_pkt_ready,
  output logic [AXI_ADDR_WIDTH-1:0]      write_desc_addr,
  output logic [LEN_WIDTH-1:0]           write_desc_len,
  output logic [TAG_WIDTH-1:0]           write_desc_tag,
  output logic                           write_desc_valid,
  input  logic                           write_desc_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]      feedback_addr,
  input  logic                           feedback_valid,
  output logic                           feedback_ready,
  output logic [$clog2(NUM_SLOTS+1)-1:0] slots_used,
  output logic                           err_oversize,
  output logic                           err_bad_free
);

  localparam int SLOT_BITS = $clog2(SLOT_SIZE);
  localparam int IDX_W     = $clog2(NUM_SLOTS);
  localparam int CNT_W     = $clog2(NUM_SLOTS+1);
  localparam logic [LEN_WIDTH-1:0]      SLOT_LEN  = LEN_WIDTH'(SLOT_SIZE);
  localparam logic [AXI_ADDR_WIDTH-1:0] SLOT_LIM  = AXI_ADDR_WIDTH'(NUM_SLOTS);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t                    state;
  logic                      rstn_q;
  logic [NUM_SLOTS-1:0]      used_map;     // 1 = slot occupied
  logic [IDX_W-1:0]          alloc_idx;
  logic                      any_free;
  logic                      accept;
  logic                      oversize;
  logic                      fb_fire;
  logic [AXI_ADDR_WIDTH-1:0] fb_off;
  logic [AXI_ADDR_WIDTH-1:0] fb_idx_full;
  logic [IDX_W-1:0]          fb_idx;
  logic                      fb_in_range;
  logic                      fb_good;

  // Lowest-index free slot, taken from the bitmap as it stands this cycle
  always_comb begin
    alloc_idx = '0;
    any_free  = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!used_map[i]) begin
        alloc_idx = IDX_W'(i);
        any_free  = 1'b1;
      end
    end
  end

  // Request handshake: the output register can take a new descriptor when
  // it is empty or is being drained this cycle, and a slot is available
  assign s_pkt_ready    = rstn_q && ((state == EMPTY) || write_desc_ready) && any_free;
  assign accept         = s_pkt_valid && s_pkt_ready;
  assign oversize       = (s_pkt_len > SLOT_LEN);
  assign feedback_ready = rstn_q;
  assign write_desc_valid = (state == FULL);

  // Free decode: offset bits below the slot size are ignored
  assign fb_fire     = feedback_valid && feedback_ready;
  assign fb_off      = feedback_addr - BUF_START;
  assign fb_idx_full = fb_off >> SLOT_BITS;
  assign fb_idx      = fb_idx_full[IDX_W-1:0];
  assign fb_in_range = (feedback_addr >= BUF_START) && (fb_idx_full < SLOT_LIM);
  assign fb_good     = fb_fire && fb_in_range && used_map[fb_idx];

  // Output-register FSM: loads a descriptor on accept, drains on DMA ready
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state           <= EMPTY;
      write_desc_addr <= '0;
      write_desc_len  <= '0;
      write_desc_tag  <= '0;
      err_oversize    <= 1'b0;
    end else begin
      err_oversize <= accept && oversize;
      case (state)
        EMPTY: begin
          if (accept) begin
            state <= FULL;
          end
        end
        FULL: begin
          if (write_desc_ready && !accept) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
      if (accept) begin
        write_desc_addr <= BUF_START + (AXI_ADDR_WIDTH'(alloc_idx) << SLOT_BITS);
        write_desc_len  <= oversize ? SLOT_LEN : s_pkt_len;
        write_desc_tag  <= s_pkt_tag;
      end
    end
  end

  // Slot bookkeeping: allocation and free are disjoint (an allocated slot is
  // free, a freed slot is used), so both may update the bitmap together
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rstn_q       <= 1'b0;
      used_map     <= '0;
      slots_used   <= '0;
      err_bad_free <= 1'b0;
    end else begin
      rstn_q       <= 1'b1;
      err_bad_free <= fb_fire && !fb_good;
      if (accept) begin
        used_map[alloc_idx] <= 1'b1;
      end
      if (fb_good) begin
        used_map[fb_idx] <= 1'b0;
      end
      slots_used <= slots_used + CNT_W'(accept) - CNT_W'(fb_good);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pspin_pkt_alloc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pspin_pkt_alloc
//  Purpose  : Directed self-checking bench for pspin_pkt_alloc.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pspin_pkt_alloc;

  localparam int BASE = 32'h1c40_0000;

  logic        clk;
  logic        rstn;
  logic [19:0] s_pkt_len;
  logic [31:0] s_pkt_tag;
  logic        s_pkt_valid;
  logic        s_pkt_ready;
  logic [31:0] write_desc_addr;
  logic [19:0] write_desc_len;
  logic [31:0] write_desc_tag;
  logic        write_desc_valid;
  logic        write_desc_ready;
  logic [31:0] feedback_addr;
  logic        feedback_valid;
  logic        feedback_ready;
  logic [5:0]  slots_used;
  logic        err_oversize;
  logic        err_bad_free;

  int checks = 0;
  int errors = 0;

  pspin_pkt_alloc dut (
    .clk              (clk),
    .rstn             (rstn),
    .s_pkt_len        (s_pkt_len),
    .s_pkt_tag        (s_pkt_tag),
    .s_pkt_valid      (s_pkt_valid),
    .s_pkt_ready      (s_pkt_ready),
    .write_desc_addr  (write_desc_addr),
    .write_desc_len   (write_desc_len),
    .write_desc_tag   (write_desc_tag),
    .write_desc_valid (write_desc_valid),
    .write_desc_ready (write_desc_ready),
    .feedback_addr    (feedback_addr),
    .feedback_valid   (feedback_valid),
    .feedback_ready   (feedback_ready),
    .slots_used       (slots_used),
    .err_oversize     (err_oversize),
    .err_bad_free     (err_bad_free)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; drive and sample 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Issue one valid free pulse and let it take effect
  task automatic do_free(input logic [31:0] a);
    feedback_addr  = a;
    feedback_valid = 1'b1;
    tick();
    feedback_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; s_pkt_len = '0; s_pkt_tag = '0; s_pkt_valid = 1'b0;
    write_desc_ready = 1'b1; feedback_addr = '0; feedback_valid = 1'b0;
    tick(); tick();
    // Reset state
    chk("rst_valid", write_desc_valid, 0);
    chk("rst_used", slots_used, 0);
    chk("rst_ready", s_pkt_ready, 0);
    chk("rst_fbready", feedback_ready, 0);
    chk("rst_addr", write_desc_addr, 0);
    chk("rst_errs", {err_oversize, err_bad_free}, 0);
    rstn = 1'b1;
    s_pkt_valid = 1'b1; s_pkt_len = 20'd64; s_pkt_tag = 32'hA5;
    settle();
    chk("post_rst_ready_low", s_pkt_ready, 0);
    tick();
    chk("fbready_up", feedback_ready, 1);
    chk("still_empty", write_desc_valid, 0);

    // T1 single accept
    chk("t1_ready", s_pkt_ready, 1);
    tick();
    s_pkt_valid = 1'b0;
    chk("t1_valid", write_desc_valid, 1);
    chk("t1_addr", write_desc_addr, BASE);
    chk("t1_len", write_desc_len, 64);
    chk("t1_tag", write_desc_tag, 32'hA5);
    chk("t1_used", slots_used, 1);
    chk("t1_ovs", err_oversize, 0);
    tick();
    chk("t1_drain", write_desc_valid, 0);
    do_free(BASE);
    settle();
    chk("t1_free", slots_used, 0);

    // T2 fill all 32 slots back-to-back
    s_pkt_valid = 1'b1;
    for (int n = 0; n < 32; n++) begin
      s_pkt_len = 20'(100 + n);
      s_pkt_tag = 32'(n);
      tick();
      chk("t2_addr", write_desc_addr, BASE + n * 32'h800);
      chk("t2_tag", write_desc_tag, n);
      chk("t2_vld", write_desc_valid, 1);
    end
    chk("t2_used", slots_used, 32);
    chk("t2_stall", s_pkt_ready, 0);
    tick();
    chk("t2_drain", write_desc_valid, 0);
    chk("t2_stall2", s_pkt_ready, 0);
    tick();
    chk("t2_stall3", s_pkt_ready, 0);
    chk("t2_used2", slots_used, 32);
    s_pkt_valid = 1'b0;

    // T3 out-of-order free and reuse of the lowest slot
    do_free(BASE + 32'h1800);
    settle();
    chk("t3_used31", slots_used, 31);
    chk("t3_nobad", err_bad_free, 0);
    do_free(BASE + 32'h0800);
    settle();
    chk("t3_used30", slots_used, 30);
    s_pkt_valid = 1'b1;
    settle();
    chk("t3_ready", s_pkt_ready, 1);
    tick();
    chk("t3_addr1", write_desc_addr, BASE + 32'h0800);
    chk("t3_used_a", slots_used, 31);
    tick();
    chk("t3_addr3", write_desc_addr, BASE + 32'h1800);
    chk("t3_used_b", slots_used, 32);
    s_pkt_valid = 1'b0;
    tick();

    // T4 full buffer: free and request in the same cycle
    feedback_addr = BASE + 32'h2800; feedback_valid = 1'b1; s_pkt_valid = 1'b1;
    settle();
    chk("t4_notready", s_pkt_ready, 0);
    tick();
    feedback_valid = 1'b0;
    settle();
    chk("t4_used31", slots_used, 31);
    chk("t4_desc_idle", write_desc_valid, 0);
    chk("t4_ready", s_pkt_ready, 1);
    tick();
    chk("t4_addr", write_desc_addr, BASE + 32'h2800);
    chk("t4_used32", slots_used, 32);
    s_pkt_valid = 1'b0;
    tick();

    // Alloc and free together when not full: count unchanged, freed slot not reused yet
    do_free(BASE + 32'h3800);
    feedback_addr = BASE + 32'h4800; feedback_valid = 1'b1; s_pkt_valid = 1'b1;
    settle();
    chk("sim_ready", s_pkt_ready, 1);
    tick();
    feedback_valid = 1'b0;
    chk("sim_addr", write_desc_addr, BASE + 32'h3800);
    chk("sim_used", slots_used, 31);
    tick();
    chk("sim_addr2", write_desc_addr, BASE + 32'h4800);
    chk("sim_used2", slots_used, 32);
    s_pkt_valid = 1'b0;
    tick();

    // T5 errors and length boundaries
    do_free(BASE + 32'h1000);
    s_pkt_valid = 1'b1; s_pkt_len = 20'd3000; s_pkt_tag = 32'h55;
    tick();
    s_pkt_valid = 1'b0;
    chk("t5_len_clamp", write_desc_len, 2048);
    chk("t5_ovs", err_oversize, 1);
    chk("t5_ovs_addr", write_desc_addr, BASE + 32'h1000);
    tick();
    chk("t5_ovs_pulse", err_oversize, 0);
    do_free(32'h1c50_0000);
    chk("t5_bad_range", err_bad_free, 1);
    chk("t5_bad_used", slots_used, 32);
    tick();
    chk("t5_bad_pulse", err_bad_free, 0);
    do_free(BASE);
    chk("t5_good_free", err_bad_free, 0);
    chk("t5_used31", slots_used, 31);
    do_free(BASE);
    chk("t5_double", err_bad_free, 1);
    chk("t5_double_used", slots_used, 31);
    do_free(32'h1c3f_f800);
    chk("t5_below", err_bad_free, 1);
    chk("t5_below_used", slots_used, 31);
    s_pkt_valid = 1'b1; s_pkt_len = 20'd0; s_pkt_tag = 32'h7;
    tick();
    s_pkt_valid = 1'b0;
    chk("t5_len0", write_desc_len, 0);
    chk("t5_len0_addr", write_desc_addr, BASE);
    chk("t5_len0_ovs", err_oversize, 0);
    chk("t5_len0_used", slots_used, 32);
    do_free(BASE + 32'h2123);
    chk("t5_lowbits", err_bad_free, 0);
    chk("t5_lowbits_used", slots_used, 31);
    s_pkt_valid = 1'b1; s_pkt_len = 20'd2048;
    tick();
    s_pkt_valid = 1'b0;
    chk("t5_len2048", write_desc_len, 2048);
    chk("t5_len2048_ovs", err_oversize, 0);
    chk("t5_len2048_addr", write_desc_addr, BASE + 32'h2000);
    tick();

    // T6 backpressure then reset mid-operation
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    write_desc_ready = 1'b0;
    s_pkt_valid = 1'b1; s_pkt_len = 20'd500; s_pkt_tag = 32'h111;
    tick();
    s_pkt_len = 20'd600; s_pkt_tag = 32'h222;
    settle();
    chk("t6_ready0", s_pkt_ready, 0);
    for (int k = 0; k < 3; k++) tick();
    chk("t6_hold_addr", write_desc_addr, BASE);
    chk("t6_hold_tag", write_desc_tag, 32'h111);
    chk("t6_hold_len", write_desc_len, 500);
    chk("t6_hold_vld", write_desc_valid, 1);
    chk("t6_used1", slots_used, 1);
    write_desc_ready = 1'b1;
    settle();
    chk("t6_ready1", s_pkt_ready, 1);
    tick();
    write_desc_ready = 1'b0;
    s_pkt_tag = 32'h333;
    chk("t6_b2b_addr", write_desc_addr, BASE + 32'h0800);
    chk("t6_b2b_tag", write_desc_tag, 32'h222);
    tick();
    chk("t6_hold2_tag", write_desc_tag, 32'h222);
    chk("t6_used2", slots_used, 2);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    s_pkt_valid = 1'b0;
    chk("t6_rst_vld", write_desc_valid, 0);
    chk("t6_rst_used", slots_used, 0);
    chk("t6_rst_addr", write_desc_addr, 0);
    chk("t6_rst_ready", s_pkt_ready, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
